axis_pkt_gen: RTL and testbench
===============================

// Module: axis_pkt_gen
// PURPOSE
//   AXI4-Stream packet transmitter (master) for the axis register-slice test chain.
//   On a start command it emits num_pkts packets of pkt_len beats each.
//   Beat data is an incrementing count from seed; tlast marks the final beat of each packet.
//   Optional idle-gap cycles separate packets.
//   Sits upstream of the stream slices; drives their s_axis side.
// PARAMETERS
//   DATA_WIDTH  32  width of m_axis_tdata and of the data counter
//   LEN_WIDTH   16  width of pkt_len and of the beat counter
//   CNT_WIDTH   16  width of num_pkts and pkt_sent
//   GAP_WIDTH    8  width of gap and of the gap counter
// PORTS
//   clk            in   1           clock; all logic on the rising edge
//   reset          in   1           asynchronous, active-high reset
//   start          in   1           one-cycle command pulse; sampled only in IDLE
//   pkt_len        in   LEN_WIDTH   beats per packet; latched on start
//   num_pkts       in   CNT_WIDTH   packets per run; latched on start
//   gap            in   GAP_WIDTH   idle cycles between packets; latched on start
//   seed           in   DATA_WIDTH  first tdata value; latched on start
//   abort          in   1           level; stops the run at the next packet boundary
//   busy           out  1           high whenever state != IDLE
//   done           out  1           one-cycle pulse at end of run
//   pkt_sent       out  CNT_WIDTH   packets completed in current/last run
//   m_axis_tdata   out  DATA_WIDTH  stream data
//   m_axis_tvalid  out  1           stream valid
//   m_axis_tready  in   1           stream ready from downstream
//   m_axis_tlast   out  1           last beat of packet
// BEHAVIOUR
//   - Reset (async): state=IDLE; tvalid, tlast, busy and done = 0; tdata=0; pkt_sent=0; all counters cleared.
//   - All outputs are registered. No combinational path exists from tready to any output.
//   - FSM states: IDLE, SEND, GAP, DONE.
//   - IDLE: start=1 latches the inputs and clears pkt_sent, beat_cnt and abort_req; data_cnt <= seed.
//       If pkt_len==0 or num_pkts==0 -> DONE; no beats are sent.
//       Otherwise -> SEND; tvalid is high in the cycle after start is sampled.
//   - SEND: tvalid=1 and tdata=data_cnt. tlast=1 exactly when beat_cnt==pkt_len-1.
//       A handshake is tvalid&tready. On a handshake: data_cnt+1 (wraps mod 2^DATA_WIDTH) and beat_cnt+1.
//       Without a handshake, tdata, tlast and tvalid hold stable. tvalid never drops without a handshake.
//   - Last-beat handshake: beat_cnt is cleared and pkt_sent+1. Next state:
//       DONE if pkt_sent+1==num_pkts or abort_req is set;
//       SEND if gap==0 (back-to-back; tvalid stays high, tlast drops);
//       GAP otherwise (tvalid=0, tlast=0).
//   - abort: a level of 1 in SEND or GAP sets abort_req.
//       In SEND, the current packet always completes with tlast, then DONE.
//       In GAP, next state is DONE and no new packet starts.
//   - GAP: holds tvalid=0 for exactly gap cycles, then SEND.
//   - DONE: done=1 for one cycle -> IDLE. pkt_sent holds until the next start.
//   - start outside IDLE is ignored.
//   - Reset mid-packet: outputs drop immediately. The protocol exemption applies only to reset.
// STRUCTURE
//   - Shared package axis_tb_pkg: FSM state encodings (2-bit localparams IDLE/SEND/GAP/DONE).
//     Shared stream-width defaults also live there.
//   - Single flat module; no sub-module. Target is about 150-250 lines of RTL.
// TESTING
//   1. pkt_len=4, num_pkts=1, gap=0, seed=0x100, tready=1
//      -> tdata 0x100..0x103; tlast only on 0x103; done 1 cycle after it; pkt_sent=1.
//   2. Same setup, tready pattern 1,0,1,0...
//      -> each beat held stable while tready=0; same 4 values; no beat lost or duplicated.
//   3. pkt_len=2, num_pkts=3, gap=0, seed=0, tready=1
//      -> 6 consecutive beats 0..5; tvalid never low; tlast on 1, 3, 5; pkt_sent=3.
//   4. pkt_len=1, num_pkts=2, gap=3
//      -> exactly 3 cycles tvalid=0 between the two beats; busy high throughout.
//   5. pkt_len=0 -> no tvalid, done 1 cycle later.
//      Next: pkt_len=4, num_pkts=5, abort pulsed on beat 2 of packet 1
//      -> packet 1 completes with tlast; then done; pkt_sent=1.
//   6. reset asserted mid-packet with tready=0
//      -> tvalid, tlast and tdata go to 0 immediately.
//      A new start after reset restarts from seed with pkt_sent cleared.

Source files
------------

// File: rtl/axis_tb_pkg.sv
// Shared definitions for the axis register-slice test chain: FSM state
// encodings and the default stream/counter widths.
package axis_tb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_GAP_WIDTH  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    GAP  = ST_GAP,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator. A start pulse launches num_pkts packets of
// pkt_len beats; beat data counts up from seed, tlast marks each packet end,
// and gap idle cycles separate packets. All outputs come from flops, so
// tready only steers next-state decisions.
module axis_pkt_gen
  import axis_tb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int GAP_WIDTH  = DEF_GAP_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [CNT_WIDTH-1:0]  num_pkts,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkt_sent,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  state_e                 state_r;
  logic [LEN_WIDTH-1:0]   len_r;
  logic [CNT_WIDTH-1:0]   num_r;
  logic [GAP_WIDTH-1:0]   gap_r;
  logic [GAP_WIDTH-1:0]   gap_cnt_r;
  logic [LEN_WIDTH-1:0]   beat_cnt_r;
  logic [DATA_WIDTH-1:0]  data_cnt_r;
  logic [CNT_WIDTH-1:0]   pkt_sent_r;
  logic                   abort_req_r;
  logic                   tvalid_r;
  logic                   tlast_r;
  logic                   busy_r;
  logic                   done_r;

  logic                   hs_s;
  logic                   abort_req_s;
  logic                   last_pkt_s;
  logic                   single_beat_s;

  // A level on abort counts in the same cycle it is seen, so an abort on the
  // final beat of a packet already ends the run at that boundary.
  assign hs_s          = tvalid_r & m_axis_tready;
  assign abort_req_s   = abort_req_r | abort;
  assign last_pkt_s    = ((pkt_sent_r + CNT_WIDTH'(1)) == num_r);
  assign single_beat_s = (len_r == LEN_WIDTH'(1));

  assign busy          = busy_r;
  assign done          = done_r;
  assign pkt_sent      = pkt_sent_r;
  assign m_axis_tdata  = data_cnt_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tlast  = tlast_r;

  // Packet FSM with all stream and status outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      len_r       <= '0;
      num_r       <= '0;
      gap_r       <= '0;
      gap_cnt_r   <= '0;
      beat_cnt_r  <= '0;
      data_cnt_r  <= '0;
      pkt_sent_r  <= '0;
      abort_req_r <= 1'b0;
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            len_r       <= pkt_len;
            num_r       <= num_pkts;
            gap_r       <= gap;
            data_cnt_r  <= seed;
            pkt_sent_r  <= '0;
            beat_cnt_r  <= '0;
            abort_req_r <= 1'b0;
            busy_r      <= 1'b1;
            if ((pkt_len == '0) || (num_pkts == '0)) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r  <= SEND;
              tvalid_r <= 1'b1;
              tlast_r  <= (pkt_len == LEN_WIDTH'(1));
            end
          end
        end
        SEND: begin
          abort_req_r <= abort_req_s;
          if (hs_s) begin
            data_cnt_r <= data_cnt_r + DATA_WIDTH'(1);
            if (tlast_r) begin
              beat_cnt_r <= '0;
              pkt_sent_r <= pkt_sent_r + CNT_WIDTH'(1);
              if (last_pkt_s || abort_req_s) begin
                state_r  <= DONE;
                tvalid_r <= 1'b0;
                tlast_r  <= 1'b0;
                done_r   <= 1'b1;
              end else if (gap_r == '0) begin
                tlast_r <= single_beat_s;
              end else begin
                state_r   <= GAP;
                tvalid_r  <= 1'b0;
                tlast_r   <= 1'b0;
                gap_cnt_r <= gap_r - GAP_WIDTH'(1);
              end
            end else begin
              beat_cnt_r <= beat_cnt_r + LEN_WIDTH'(1);
              tlast_r    <= ((beat_cnt_r + LEN_WIDTH'(1)) == (len_r - LEN_WIDTH'(1)));
            end
          end
        end
        GAP: begin
          abort_req_r <= abort_req_s;
          if (abort_req_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else if (gap_cnt_r == '0) begin
            state_r  <= SEND;
            tvalid_r <= 1'b1;
            tlast_r  <= single_beat_s;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_WIDTH'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: directed runs plus randomized runs,
// each compared against a beat list built from seed/length/count arithmetic.
module tb_axis_pkt_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pkt_len = 16'd0;
  logic [15:0] num_pkts = 16'd0;
  logic [7:0]  gap = 8'd0;
  logic [31:0] seed = 32'd0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] pkt_sent;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  axis_pkt_gen dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pkt_len       (pkt_len),
    .num_pkts      (num_pkts),
    .gap           (gap),
    .seed          (seed),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .pkt_sent      (pkt_sent),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run: mode 0 = always ready, 1 = alternating ready, 2 = random ready.
  // ab >= 0 pulses abort while global beat index ab is on the bus (mid-packet).
  task automatic run_pkt(input int len, input int num, input int g, input logic [31:0] sd,
                         input int mode, input int ab, input string tag);
    beat_t       exp_q[$];
    beat_t       got_q[$];
    int          idle_q[$];
    int          pkts, total, beats, cur_idle, done_cyc, last_hs, exp_idle;
    bit          ab_fired, finished;
    logic        pv, pr, pl;
    logic [31:0] pd;

    if (len == 0 || num == 0) pkts = 0;
    else if (ab >= 0) pkts = (ab / len + 1 < num) ? ab / len + 1 : num;
    else pkts = num;
    total = pkts * len;
    for (int i = 0; i < total; i++) exp_q.push_back('{data: sd + 32'(i), last: ((i % len) == len - 1)});
    exp_idle = (g == 0 || pkts < 2) ? 0 : pkts - 1;

    beats = 0; cur_idle = 0; done_cyc = -1; last_hs = -1;
    ab_fired = 1'b0; finished = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 32'd0;

    @(posedge clk); #1;
    pkt_len = 16'(len); num_pkts = 16'(num); gap = 8'(g); seed = sd;
    start = 1'b1; abort = 1'b0; m_axis_tready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 2 == 0);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      abort = 1'b0;
      if (ab >= 0 && !ab_fired && beats == ab) begin
        abort = 1'b1;
        ab_fired = 1'b1;
      end
      if (cyc == 1 && total >= 2) begin
        start = 1'b1;
        pkt_len = 16'($urandom); num_pkts = 16'($urandom); gap = 8'($urandom); seed = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) chk({tag, " first_tvalid"}, 64'(m_axis_tvalid), 64'(pkts > 0));
      if (pv && !pr) begin
        chk({tag, " hold_valid"}, 64'(m_axis_tvalid), 64'd1);
        chk({tag, " hold_data"}, 64'(m_axis_tdata), 64'(pd));
        chk({tag, " hold_last"}, 64'(m_axis_tlast), 64'(pl));
      end
      chk({tag, " busy"}, 64'(busy), 64'd1);
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back('{data: m_axis_tdata, last: m_axis_tlast});
        beats++;
        last_hs = cyc;
      end
      if (!m_axis_tvalid && beats > 0 && !done) cur_idle++;
      else if (m_axis_tvalid && cur_idle > 0) begin
        idle_q.push_back(cur_idle);
        cur_idle = 0;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        finished = 1'b1;
        chk({tag, " pkt_sent_at_done"}, 64'(pkt_sent), 64'(pkts));
      end
      pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata; pl = m_axis_tlast;
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; m_axis_tready = 1'b0;
    if (!finished) chk({tag, " timeout"}, 64'd0, 64'd1);

    @(negedge clk);
    chk({tag, " done_pulse_end"}, 64'(done), 64'd0);
    chk({tag, " busy_end"}, 64'(busy), 64'd0);
    chk({tag, " tvalid_end"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, " pkt_sent_hold"}, 64'(pkt_sent), 64'(pkts));
    chk({tag, " beat_count"}, 64'(got_q.size()), 64'(total));
    for (int i = 0; i < total && i < got_q.size(); i++) begin
      chk({tag, " tdata"}, 64'(got_q[i].data), 64'(exp_q[i].data));
      chk({tag, " tlast"}, 64'(got_q[i].last), 64'(exp_q[i].last));
    end
    chk({tag, " done_timing"}, 64'(done_cyc), 64'((pkts > 0) ? last_hs + 1 : 0));
    chk({tag, " gap_runs"}, 64'(idle_q.size()), 64'(exp_idle));
    for (int i = 0; i < idle_q.size(); i++) chk({tag, " gap_len"}, 64'(idle_q[i]), 64'(g));
  endtask

  initial begin
    logic [31:0] sd;
    int          len, num, g, ab, pk;

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("reset tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset tlast", 64'(m_axis_tlast), 64'd0);
    chk("reset tdata", 64'(m_axis_tdata), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset pkt_sent", 64'(pkt_sent), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed runs
    run_pkt(4, 1, 0, 32'h0000_0100, 0, -1, "t1_basic");
    run_pkt(4, 1, 0, 32'h0000_0100, 1, -1, "t2_backpressure");
    run_pkt(2, 3, 0, 32'h0000_0000, 0, -1, "t3_back_to_back");
    run_pkt(1, 2, 3, $urandom, 0, -1, "t4_gap");
    run_pkt(0, 3, 2, $urandom, 2, -1, "t5_zero_len");
    run_pkt(5, 0, 1, $urandom, 2, -1, "t5_zero_num");
    run_pkt(4, 5, 2, $urandom, 2, 2, "t5_abort");
    run_pkt(3, 3, 1, 32'hFFFF_FFFE, 2, -1, "wrap");

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 5);
      num = $urandom_range(1, 4);
      g   = $urandom_range(0, 3);
      sd  = $urandom;
      ab  = -1;
      if (len >= 2 && $urandom_range(0, 1) == 1) begin
        pk = $urandom_range(0, num - 1);
        ab = pk * len + $urandom_range(1, len - 1);
      end
      run_pkt(len, num, g, sd, 2, ab, "random");
    end

    // Reset mid-packet with tready low
    sd = $urandom;
    @(posedge clk); #1;
    pkt_len = 16'd2; num_pkts = 16'd3; gap = 8'd0; seed = sd;
    start = 1'b1; m_axis_tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 m_axis_tready = 1'b0;
    @(negedge clk);
    chk("t6 pre_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("t6 pre_tdata", 64'(m_axis_tdata), 64'(sd + 32'd3));
    chk("t6 pre_tlast", 64'(m_axis_tlast), 64'd1);
    chk("t6 pre_pkt_sent", 64'(pkt_sent), 64'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t6 rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t6 rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("t6 rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("t6 rst_busy", 64'(busy), 64'd0);
    chk("t6 rst_pkt_sent", 64'(pkt_sent), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_pkt(3, 2, 1, $urandom, 2, -1, "t6_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
